uart_frame_parser: RTL and testbench

- Downstream consumer of the UART receive FIFO. It pops received bytes, hunts for a start-of-frame byte, and assembles length-prefixed frames into an internal payload buffer.
- It checks the XOR checksum, then streams the verified payload out over a valid/ready byte interface.
- Bad, oversized or stalled frames are dropped and flagged.
- Sits between the UART core's bus_data_out / RX status bits and the command-processing logic.

---
 rtl/uart_frame_parser.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Pops bytes from the UART RX FIFO, hunts for SOF, assembles a length-prefixed
// frame (SOF, LEN, payload, CHK) into a local buffer, verifies the XOR checksum
// (CHK = LEN ^ payload bytes) and streams the verified payload out on a
// valid/ready byte interface. Bad length, bad checksum and inter-byte timeout
// drop the frame and raise a one-cycle error pulse.
// Optional build macro: UART_FRAME_STATS_EN adds saturating good/bad frame counters.
// The FIFO pop strobe is registered: a pop is requested from the current empty
// flag and the byte is captured during the strobe cycle, so pops are never
// back to back and never fall in S_OUT.
module uart_frame_parser #(
    parameter int                   DATA_SIZE      = 8,
    parameter int                   MAX_PAYLOAD    = 16,
    parameter logic [DATA_SIZE-1:0] SOF_BYTE       = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 200000,
    parameter int                   LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [DATA_SIZE-1:0] rx_data,
    output logic                 rx_read,
    output logic                 pay_valid,
    input  logic                 pay_ready,
    output logic [DATA_SIZE-1:0] pay_data,
    output logic                 pay_last,
    output logic [LEN_W-1:0]     pay_len,
    output logic                 chk_error,
    output logic                 len_error,
    output logic                 timeout_error,
`ifdef UART_FRAME_STATS_EN
    output logic [15:0]          good_frames,
    output logic [15:0]          bad_frames,
`endif
    output logic                 busy
);

    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    // Checksum fold: running XOR of LEN and every payload byte.
    function automatic logic [DATA_SIZE-1:0] chk_fold(input logic [DATA_SIZE-1:0] acc,
                                                      input logic [DATA_SIZE-1:0] b);
        return acc ^ b;
    endfunction

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_wr_ptr;
    logic [LEN_W-1:0]     r_rd_ptr;
    logic [DATA_SIZE-1:0] r_acc;
    logic [TW-1:0]        r_cnt;
    logic [DATA_SIZE-1:0] r_buf [MAX_PAYLOAD];
    logic                 r_rx_read;
    logic                 r_pay_valid;
    logic [DATA_SIZE-1:0] r_pay_data;
    logic                 r_pay_last;
    logic [LEN_W-1:0]     r_pay_len;
    logic                 r_chk_error;
    logic                 r_len_error;
    logic                 r_timeout_error;
    logic                 r_busy;

    state_t               w_state_nx;
    logic [LEN_W-1:0]     w_len_nx;
    logic [LEN_W-1:0]     w_wr_ptr_nx;
    logic [LEN_W-1:0]     w_rd_ptr_nx;
    logic [DATA_SIZE-1:0] w_acc_nx;
    logic [TW-1:0]        w_cnt_nx;
    logic                 w_buf_we;
    logic                 w_chk_err;
    logic                 w_len_err;
    logic                 w_to_err;
    logic                 w_byte;
    logic                 w_xfer;
    logic                 w_timed;
    logic                 w_pop_nx;

    assign w_byte  = r_rx_read;                 // rx_data is the popped byte this cycle
    assign w_xfer  = r_pay_valid & pay_ready;
    assign w_timed = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // Request a pop only if the FIFO shows data, no pop is in flight and the
    // cycle that will carry the strobe is an intake state.
    assign w_pop_nx = !rx_empty && !r_rx_read && (w_state_nx != S_OUT);

    // Next-state, datapath and error-pulse decode for the frame FSM.
    always_comb begin
        w_state_nx  = r_state;
        w_len_nx    = r_len;
        w_wr_ptr_nx = r_wr_ptr;
        w_rd_ptr_nx = r_rd_ptr;
        w_acc_nx    = r_acc;
        w_cnt_nx    = r_cnt;
        w_buf_we    = 1'b0;
        w_chk_err   = 1'b0;
        w_len_err   = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_byte && (rx_data == SOF_BYTE)) begin
                    w_state_nx = S_LEN;
                    w_acc_nx   = {DATA_SIZE{1'b0}};
                end else begin
                    w_state_nx = S_HUNT;
                end
            end
            S_LEN: begin
                if (w_byte) begin
                    if ((rx_data == {DATA_SIZE{1'b0}}) || (rx_data > DATA_SIZE'(MAX_PAYLOAD))) begin
                        w_len_err  = 1'b1;
                        w_state_nx = S_HUNT;
                    end else begin
                        w_len_nx    = rx_data[LEN_W-1:0];
                        w_acc_nx    = rx_data;
                        w_wr_ptr_nx = {LEN_W{1'b0}};
                        w_state_nx  = S_PAYLOAD;
                    end
                end else begin
                    w_state_nx = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (w_byte) begin
                    w_buf_we    = 1'b1;
                    w_acc_nx    = chk_fold(r_acc, rx_data);
                    w_wr_ptr_nx = r_wr_ptr + LEN_W'(1);
                    if (w_wr_ptr_nx == r_len) begin
                        w_state_nx = S_CHK;
                    end else begin
                        w_state_nx = S_PAYLOAD;
                    end
                end else begin
                    w_state_nx = S_PAYLOAD;
                end
            end
            S_CHK: begin
                if (w_byte) begin
                    if (rx_data == r_acc) begin
                        w_state_nx  = S_OUT;
                        w_rd_ptr_nx = {LEN_W{1'b0}};
                    end else begin
                        w_chk_err  = 1'b1;
                        w_state_nx = S_HUNT;
                    end
                end else begin
                    w_state_nx = S_CHK;
                end
            end
            S_OUT: begin
                if (w_xfer) begin
                    if (r_pay_last) begin
                        w_state_nx  = S_HUNT;
                        w_rd_ptr_nx = {LEN_W{1'b0}};
                    end else begin
                        w_rd_ptr_nx = r_rd_ptr + LEN_W'(1);
                    end
                end else begin
                    w_state_nx = S_OUT;
                end
            end
            default: begin
                w_state_nx = S_HUNT;
            end
        endcase
        // Inter-byte timer: an accepted byte always beats an expiring timer.
        if (w_timed) begin
            if (w_byte) begin
                w_cnt_nx = {TW{1'b0}};
            end else if (r_cnt == TW'(TIMEOUT_CYCLES - 2)) begin
                w_to_err   = 1'b1;
                w_state_nx = S_HUNT;
                w_cnt_nx   = {TW{1'b0}};
            end else begin
                w_cnt_nx = r_cnt + TW'(1);
            end
        end else begin
            w_cnt_nx = {TW{1'b0}};
        end
    end

    // State, counters and all registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_HUNT;
            r_len           <= {LEN_W{1'b0}};
            r_wr_ptr        <= {LEN_W{1'b0}};
            r_rd_ptr        <= {LEN_W{1'b0}};
            r_acc           <= {DATA_SIZE{1'b0}};
            r_cnt           <= {TW{1'b0}};
            r_rx_read       <= 1'b0;
            r_pay_valid     <= 1'b0;
            r_pay_data      <= {DATA_SIZE{1'b0}};
            r_pay_last      <= 1'b0;
            r_pay_len       <= {LEN_W{1'b0}};
            r_chk_error     <= 1'b0;
            r_len_error     <= 1'b0;
            r_timeout_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_len           <= w_len_nx;
            r_wr_ptr        <= w_wr_ptr_nx;
            r_rd_ptr        <= w_rd_ptr_nx;
            r_acc           <= w_acc_nx;
            r_cnt           <= w_cnt_nx;
            r_rx_read       <= w_pop_nx;
            r_chk_error     <= w_chk_err;
            r_len_error     <= w_len_err;
            r_timeout_error <= w_to_err;
            r_busy          <= (w_state_nx != S_HUNT);
            if (w_state_nx == S_OUT) begin
                r_pay_valid <= 1'b1;
                r_pay_data  <= r_buf[w_rd_ptr_nx[AW-1:0]];
                r_pay_last  <= (w_rd_ptr_nx == (r_len - LEN_W'(1)));
                r_pay_len   <= r_len;
            end else begin
                r_pay_valid <= 1'b0;
                r_pay_data  <= {DATA_SIZE{1'b0}};
                r_pay_last  <= 1'b0;
                r_pay_len   <= {LEN_W{1'b0}};
            end
        end
    end

    // Payload buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we && !reset) begin
            r_buf[r_wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    assign rx_read       = r_rx_read;
    assign pay_valid     = r_pay_valid;
    assign pay_data      = r_pay_data;
    assign pay_last      = r_pay_last;
    assign pay_len       = r_pay_len;
    assign chk_error     = r_chk_error;
    assign len_error     = r_len_error;
    assign timeout_error = r_timeout_error;
    assign busy          = r_busy;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] r_good_frames;
    logic [15:0] r_bad_frames;

    // Saturating frame statistics: delivered frames and dropped frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_good_frames <= 16'd0;
            r_bad_frames  <= 16'd0;
        end else begin
            if (w_xfer && r_pay_last && (r_good_frames != 16'hFFFF)) begin
                r_good_frames <= r_good_frames + 16'd1;
            end
            if ((w_chk_err || w_len_err || w_to_err) && (r_bad_frames != 16'hFFFF)) begin
                r_bad_frames <= r_bad_frames + 16'd1;
            end
        end
    end

    assign good_frames = r_good_frames;
    assign bad_frames  = r_bad_frames;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed testbench for uart_frame_parser (MAX_PAYLOAD=16, TIMEOUT_CYCLES=50).
// A small array-backed FIFO model feeds rx_empty/rx_data; a negedge monitor
// logs transfers, error pulses and event cycles for the scenario tasks.
module tb_uart_frame_parser;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty, rx_read, pay_valid, pay_last;
    logic       pay_ready = 1'b0;
    logic       chk_error, len_error, timeout_error, busy;
    logic [7:0] rx_data, pay_data;
    logic [4:0] pay_len;

    logic [7:0] stim [0:255];
    int         wr_idx = 0;
    int         rd_idx = 0;
    int         pop_empty_cnt = 0;

    int         total = 0;
    int         bad = 0;

    int         cyc = 0, last_pop_cyc = 0, rise_cyc = 0, to_cyc = 0;
    int         n_chk = 0, n_len = 0, n_to = 0, n_multi = 0, n_got = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_data [0:63];
    logic       got_last [0:63];
    logic [4:0] got_len  [0:63];

    assign rx_empty = (rd_idx == wr_idx);
    assign rx_data  = stim[rd_idx[7:0]];

    always #5 clk = ~clk;

    uart_frame_parser #(.MAX_PAYLOAD(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
        .rx_read(rx_read), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .pay_data(pay_data), .pay_last(pay_last), .pay_len(pay_len),
        .chk_error(chk_error), .len_error(len_error), .timeout_error(timeout_error),
        .busy(busy)
    );

    // FIFO model: pop the head on every clock edge that sees rx_read.
    always @(posedge clk) begin
        if (rx_read) begin
            if (rx_empty) pop_empty_cnt <= pop_empty_cnt + 1;
            else          rd_idx <= rd_idx + 1;
        end
    end

    // Monitor: log transfers, pulses and the cycles of interesting events.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_valid <= pay_valid;
        if (rx_read) last_pop_cyc <= cyc;
        if (pay_valid && !prev_valid) rise_cyc <= cyc;
        if (chk_error) n_chk <= n_chk + 1;
        if (len_error) n_len <= n_len + 1;
        if (timeout_error) begin n_to <= n_to + 1; to_cyc <= cyc; end
        if ((int'(chk_error) + int'(len_error) + int'(timeout_error)) > 1) n_multi <= n_multi + 1;
        if (pay_valid && pay_ready && n_got < 64) begin
            got_data[n_got] <= pay_data;
            got_last[n_got] <= pay_last;
            got_len[n_got]  <= pay_len;
            n_got <= n_got + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Push n bytes, most significant byte of v first.
    task automatic push_vec(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) begin
            stim[wr_idx[7:0]] = v[8*(n-1-i) +: 8];
            wr_idx++;
        end
    endtask

    // Wait until the FIFO is drained and the parser has been idle for 4 cycles.
    task automatic wait_idle(input int budget, output bit ok);
        int stable = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_empty && !busy && !pay_valid && !rx_read) stable++;
            else stable = 0;
            if (stable >= 4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        push_vec(2, 64'h0011);                      // garbage waiting during reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({rx_read, pay_valid, pay_data, pay_last, pay_len, chk_error, len_error, timeout_error, busy} !== 20'd0) begin
                bad++;
                $display("FAIL reset_outputs got rd=%b v=%b d=%h l=%b len=%0d err=%b%b%b busy=%b required all 0",
                         rx_read, pay_valid, pay_data, pay_last, pay_len, chk_error, len_error, timeout_error, busy);
            end
        end
        tick; reset = 1'b0;
    endtask

    task automatic test_good_frame;
        bit ok;
        int b_got = n_got, b_err = n_chk + n_len + n_to;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        pay_ready = 1'b1;
        push_vec(6, 64'hA5_03_11_22_33_03);         // CHK = 03^11^22^33 = 03
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL good_idle got timeout required idle"); end
        total++; if (n_got - b_got !== 3) begin bad++; $display("FAIL good_count got %0d required 3", n_got - b_got); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({got_data[b_got+i], got_last[b_got+i], got_len[b_got+i]} !== {exp_d[i], (i == 2), 5'd3}) begin
                bad++;
                $display("FAIL good_byte%0d got d=%h last=%b len=%0d required d=%h last=%b len=3",
                         i, got_data[b_got+i], got_last[b_got+i], got_len[b_got+i], exp_d[i], (i == 2));
            end
        end
        total++; if (n_chk + n_len + n_to - b_err !== 0) begin bad++; $display("FAIL good_errors got %0d required 0", n_chk + n_len + n_to - b_err); end
        total++;
        if ((rise_cyc - last_pop_cyc) < 1 || (rise_cyc - last_pop_cyc) > 2) begin
            bad++; $display("FAIL good_latency got %0d required 1..2", rise_cyc - last_pop_cyc);
        end
    endtask

    task automatic test_bad_checksum;
        bit ok;
        int b_got = n_got, b_chk = n_chk;
        push_vec(5, 64'hA5_02_10_20_31);            // correct CHK would be 32
        push_vec(4, 64'hA5_01_7E_7F);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL badchk_idle got timeout required idle"); end
        total++; if (n_chk - b_chk !== 1) begin bad++; $display("FAIL badchk_pulses got %0d required 1", n_chk - b_chk); end
        total++;
        if (n_got - b_got !== 1 || {got_data[b_got], got_last[b_got], got_len[b_got]} !== {8'h7E, 1'b1, 5'd1}) begin
            bad++; $display("FAIL badchk_next got n=%0d d=%h required n=1 d=7e", n_got - b_got, got_data[b_got]);
        end
    endtask

    task automatic test_len_errors;
        bit ok;
        int b_got = n_got, b_len = n_len, b_oth = n_chk + n_to;
        push_vec(2, 64'hA5_00);
        push_vec(2, 64'hA5_11);
        push_vec(4, 64'hA5_01_42_43);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL len_idle got timeout required idle"); end
        total++; if (n_len - b_len !== 2) begin bad++; $display("FAIL len_pulses got %0d required 2", n_len - b_len); end
        total++; if (n_chk + n_to - b_oth !== 0) begin bad++; $display("FAIL len_other got %0d required 0", n_chk + n_to - b_oth); end
        total++;
        if (n_got - b_got !== 1 || got_data[b_got] !== 8'h42) begin
            bad++; $display("FAIL len_next got n=%0d d=%h required n=1 d=42", n_got - b_got, got_data[b_got]);
        end
    endtask

    task automatic test_resync_sof_in_payload;
        bit ok;
        int b_got = n_got, b_err = n_chk + n_len + n_to;
        push_vec(7, 64'h00_FF_A5_02_A5_5A_FD);
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL resync_idle got timeout required idle"); end
        total++;
        if (n_got - b_got !== 2 || {got_data[b_got], got_last[b_got], got_data[b_got+1], got_last[b_got+1], got_len[b_got+1]}
                                   !== {8'hA5, 1'b0, 8'h5A, 1'b1, 5'd2}) begin
            bad++; $display("FAIL resync_payload got n=%0d d0=%h d1=%h required n=2 d0=a5 d1=5a",
                            n_got - b_got, got_data[b_got], got_data[b_got+1]);
        end
        total++; if (n_chk + n_len + n_to - b_err !== 0) begin bad++; $display("FAIL resync_errors got %0d required 0", n_chk + n_len + n_to - b_err); end
    endtask

    task automatic test_timeout;
        int b_got = n_got, b_to = n_to, b_oth = n_chk + n_len;
        push_vec(3, 64'hA5_04_01);
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_before got %b required 1", busy); end
        repeat (60) @(negedge clk);
        total++; if (n_to - b_to !== 1) begin bad++; $display("FAIL to_pulses got %0d required 1", n_to - b_to); end
        total++; if (to_cyc - last_pop_cyc !== TO) begin bad++; $display("FAIL to_delay got %0d required %0d", to_cyc - last_pop_cyc, TO); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy_after got %b required 0", busy); end
        total++;
        if (n_got - b_got !== 0 || n_chk + n_len - b_oth !== 0) begin
            bad++; $display("FAIL to_side got payload=%0d errs=%0d required 0 0", n_got - b_got, n_chk + n_len - b_oth);
        end
    endtask

    // Bytes spaced 49 cycles apart: each arrives in the cycle the timer would fire.
    task automatic test_slow_bytes;
        bit ok;
        int b_got = n_got, b_to = n_to;
        logic [39:0] frame = 40'hA5_02_10_20_32;
        for (int i = 0; i < 5; i++) begin
            push_vec(1, {56'd0, frame[8*(4-i) +: 8]});
            repeat (49) tick;
        end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL slow_idle got timeout required idle"); end
        total++; if (n_to - b_to !== 0) begin bad++; $display("FAIL slow_timeout got %0d required 0", n_to - b_to); end
        total++;
        if (n_got - b_got !== 2 || got_data[b_got] !== 8'h10 || got_data[b_got+1] !== 8'h20) begin
            bad++; $display("FAIL slow_payload got n=%0d required 2 bytes 10 20", n_got - b_got);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit seen = 1'b0;
        int b_got = n_got;
        pay_ready = 1'b0;
        push_vec(5, 64'hA5_02_C1_C2_01);
        push_vec(4, 64'hA5_01_33_32);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pay_valid) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_valid got 0 required 1"); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({rx_read, pay_valid, pay_data, pay_last, pay_len} !== {1'b0, 1'b1, 8'hC1, 1'b0, 5'd2}) begin
                bad++; $display("FAIL bp_hold%0d got rd=%b v=%b d=%h l=%b len=%0d required rd=0 v=1 d=c1 l=0 len=2",
                                i, rx_read, pay_valid, pay_data, pay_last, pay_len);
            end
        end
        total++; if (wr_idx - rd_idx !== 4) begin bad++; $display("FAIL bp_pending got %0d required 4", wr_idx - rd_idx); end
        tick; pay_ready = 1'b1;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_idle got timeout required idle"); end
        total++;
        if (n_got - b_got !== 3 ||
            {got_data[b_got], got_last[b_got], got_data[b_got+1], got_last[b_got+1], got_data[b_got+2], got_last[b_got+2], got_len[b_got+2]}
            !== {8'hC1, 1'b0, 8'hC2, 1'b1, 8'h33, 1'b1, 5'd1}) begin
            bad++; $display("FAIL bp_payload got n=%0d %h %h %h required 3 c1 c2 33",
                            n_got - b_got, got_data[b_got], got_data[b_got+1], got_data[b_got+2]);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int b_got, b_err;
        pay_ready = 1'b1;
        push_vec(4, 64'hA5_04_10_20);
        for (int i = 0; i < 50 && !rx_empty; i++) tick;
        repeat (3) tick;
        b_got = n_got;
        b_err = n_chk + n_len + n_to;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({rx_read, pay_valid, pay_data, pay_last, pay_len, chk_error, len_error, timeout_error, busy} !== 20'd0) begin
            bad++; $display("FAIL midreset_outputs got rd=%b v=%b d=%h busy=%b required all 0", rx_read, pay_valid, pay_data, busy);
        end
        tick; reset = 1'b0;
        repeat (10) tick;
        total++;
        if (n_got - b_got !== 0 || n_chk + n_len + n_to - b_err !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_quiet got payload=%0d errs=%0d busy=%b required 0 0 0",
                            n_got - b_got, n_chk + n_len + n_to - b_err, busy);
        end
        push_vec(4, 64'hA5_01_55_54);
        wait_idle(200, ok);
        total++;
        if (!ok || n_got - b_got !== 1 || got_data[b_got] !== 8'h55 || got_last[b_got] !== 1'b1) begin
            bad++; $display("FAIL midreset_next got n=%0d d=%h required n=1 d=55", n_got - b_got, got_data[b_got]);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_errors();
        test_resync_sof_in_payload();
        test_timeout();
        test_slow_bytes();
        test_backpressure();
        test_reset_mid_frame();
        total++; if (pop_empty_cnt !== 0) begin bad++; $display("FAIL pop_while_empty got %0d required 0", pop_empty_cnt); end
        total++; if (n_multi !== 0) begin bad++; $display("FAIL overlapping_errors got %0d required 0", n_multi); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
